uart_command_sequencer: RTL and testbench
=========================================

Name: uart_command_sequencer

Overview:
- Sits between the UART hex-command parser and the Wishbone master bus.
- Accepts parsed command/address/data words, each marked by a one-cycle valid pulse, and queues them in a small FIFO.
- Executes each command as one or more Wishbone classic cycles (ping, single write, or incrementing-address burst read), with an ack timeout.
- Emits one response word per bus access toward the UART output path, using a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of queued commands; power of two, minimum 2.
- TIMEOUT_CYCLES, 1024, cycles to wait for i_wbm_ack before aborting an access.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_command  input  32  parsed command word; [3:0] is the opcode
- in_address  input  32  parsed start address
- in_data  input  32  write data (write) or word count in [15:0] (read)
- in_ready  input  1  one-cycle pulse; the in_* words are valid this cycle
- o_wbm_cyc  output  1  Wishbone cycle
- o_wbm_stb  output  1  Wishbone strobe
- o_wbm_we  output  1  Wishbone write enable
- o_wbm_sel  output  4  byte selects, always 4'hF while stb is high
- o_wbm_adr  output  32  Wishbone address
- o_wbm_dat  output  32  Wishbone write data
- i_wbm_dat  input  32  Wishbone read data
- i_wbm_ack  input  1  Wishbone acknowledge
- out_status  output  32  response status word
- out_address  output  32  address of this response
- out_data  output  32  read data, written data, or 0
- out_en  output  1  response valid
- out_ready  input  1  downstream accepts the response
- o_busy  output  1  high whenever the FSM is not in IDLE or the FIFO is non-empty
- o_overflow  output  1  one-cycle pulse when a command is dropped

Behaviour:
- Reset: all outputs are 0; FIFO is emptied; FSM enters IDLE; timeout counter is 0.
- Reset mid-transaction: cyc/stb drop at the next edge, no response is emitted, and queued commands are discarded.
- Opcodes (in_command[3:0]):
  - 0x0 PING: no bus access; one response with out_data=0.
  - 0x1 WRITE: one write of in_data to in_address.
  - 0x2 READ: N reads at in_address, in_address+1, and so on, where N = in_data[15:0]; N=0 is treated as 1.
  - Any other opcode: no bus access; one response with error bit set.
- FIFO push: in_ready while not full stores {command, address, data}.
- FIFO overflow: in_ready while full drops the command and pulses o_overflow.
- Simultaneous in_ready and pop while full: the push is accepted.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and latch the entry. Go to BUS for READ/WRITE, or to RESP for PING/illegal opcodes.
  - BUS:
    - cyc=stb=1, we=(opcode==WRITE), adr=current address, dat=write data.
    - Asserted on the first cycle after the IDLE pop (registered outputs).
    - On i_wbm_ack: capture i_wbm_dat (read) or the write data into out_data; deassert cyc/stb at the next edge; go to RESP.
    - If TIMEOUT_CYCLES cycles elapse without ack: deassert cyc/stb, set the timeout bit, out_data=0, go to RESP.
    - An ack in the same cycle the count expires counts as success.
  - RESP: out_en=1 and out_* are held stable until out_ready is sampled high. On acceptance, out_en drops next cycle and:
    - READ with remaining>0 and no timeout: address+1 (wraps modulo 2^32), remaining-1, go to BUS.
    - Otherwise: go to IDLE.
- Timeout aborts the remainder of a burst.
- Latency: in_ready into an empty FIFO in IDLE gives stb high 2 cycles later (push, pop, then BUS).
- out_status fields:
  - [3:0] opcode echo
  - [4] illegal opcode
  - [5] timeout
  - [15:6] 0
  - [31:16] words remaining after this response
- The timeout counter resets to 0 on every entry to BUS.

Test Plan:
- WRITE: cmd=0x1, adr=0x100, data=0xDEADBEEF; ack after 3 cycles -> one bus cycle with we=1, adr=0x100, dat=0xDEADBEEF; response status=0x00000001, out_data=0xDEADBEEF.
- READ burst: cmd=0x2, adr=0xFFFFFFFE, data=3; slave returns 0xA0, 0xA1, 0xA2 -> reads at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; statuses 0x00020002, 0x00010002, 0x00000002.
- Timeout: READ N=2 with no ack -> stb held exactly 1024 cycles, then one response status=0x00010022, out_data=0; burst aborted; FSM returns to IDLE.
- Backpressure and overflow: out_ready=0, then 6 commands pushed (1 executing, 4 queued) -> o_overflow pulses once; out_* remain stable while waiting; all accepted commands complete in order.
- Illegal/ping: cmd=0x7 -> status=0x00000017 with no cyc; cmd=0x0 -> status=0, out_data=0, no cyc.
- Reset mid-burst: rst asserted while stb=1 -> cyc/stb=0 next cycle, FIFO empty, no out_en, o_busy=0.

Source files
------------

// File: rtl/uart_command_sequencer_if.sv
// Signal bundle between the command sequencer, the UART parser/response path
// and the Wishbone slave side. The sequencer uses the master modport.
interface uart_command_sequencer_if;
  logic [31:0] in_command;
  logic [31:0] in_address;
  logic [31:0] in_data;
  logic        in_ready;

  logic        o_wbm_cyc;
  logic        o_wbm_stb;
  logic        o_wbm_we;
  logic [3:0]  o_wbm_sel;
  logic [31:0] o_wbm_adr;
  logic [31:0] o_wbm_dat;
  logic [31:0] i_wbm_dat;
  logic        i_wbm_ack;

  logic [31:0] out_status;
  logic [31:0] out_address;
  logic [31:0] out_data;
  logic        out_en;
  logic        out_ready;

  logic        o_busy;
  logic        o_overflow;

  modport master (
    input  in_command, in_address, in_data, in_ready,
    input  i_wbm_dat, i_wbm_ack, out_ready,
    output o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_sel, o_wbm_adr, o_wbm_dat,
    output out_status, out_address, out_data, out_en, o_busy, o_overflow
  );

  modport slave (
    output in_command, in_address, in_data, in_ready,
    output i_wbm_dat, i_wbm_ack, out_ready,
    input  o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_sel, o_wbm_adr, o_wbm_dat,
    input  out_status, out_address, out_data, out_en, o_busy, o_overflow
  );
endinterface

// File: rtl/uart_command_sequencer.sv
// Queues parsed UART commands and runs them as Wishbone classic cycles,
// returning one response word per bus access over a valid/ready handshake.
module uart_command_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                      clk,
  input logic                      rst,
  uart_command_sequencer_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [3:0]    OP_WRITE   = 4'h1;
  localparam logic [3:0]    OP_READ    = 4'h2;
  localparam logic [PW:0]   FIFO_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t state_q, state_d;

  // Entry layout: {opcode[3:0], address[31:0], data[31:0]}
  logic [67:0]   fifo_mem [FIFO_DEPTH];
  logic [67:0]   head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop, drop;

  logic [3:0]    opcode_q, opcode_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   remain_q, remain_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          overflow_q, overflow_d;

  logic [3:0]    head_op;
  logic          head_is_bus;
  logic          expired;
  logic          burst_more;

  assign head        = fifo_mem[rd_ptr_q];
  assign head_op     = head[67:64];
  assign head_is_bus = (head_op == OP_WRITE) || (head_op == OP_READ);
  assign expired     = (timer_q == TIMER_LAST);
  assign burst_more  = (opcode_q == OP_READ) && (remain_q != 16'd0) && !timeout_q;

  // A pop frees a slot in the same cycle, so a push while full still lands.
  always_comb begin
    pop      = (state_q == ST_IDLE) && (count_q != '0);
    push     = bus.in_ready && ((count_q != FIFO_FULL) || pop);
    drop     = bus.in_ready && (count_q == FIFO_FULL) && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.in_command[3:0], bus.in_address, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pop) state_d = head_is_bus ? ST_BUS : ST_RESP;
      ST_BUS:  if (bus.i_wbm_ack || expired) state_d = ST_RESP;
      ST_RESP: if (bus.out_ready) state_d = burst_more ? ST_BUS : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    opcode_d   = opcode_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    remain_d   = remain_q;
    timer_d    = timer_q;
    rdata_d    = rdata_q;
    overflow_d = drop;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          opcode_d  = head_op;
          illegal_d = (head_op > OP_READ);
          timeout_d = 1'b0;
          addr_d    = head[63:32];
          wdata_d   = head[31:0];
          remain_d  = ((head_op == OP_READ) && (head[15:0] != 16'd0)) ?
                      head[15:0] - 16'd1 : 16'd0;
          timer_d   = '0;
          rdata_d   = 32'd0;
        end
      end
      ST_BUS: begin
        // An ack on the expiring cycle wins over the timeout.
        if (bus.i_wbm_ack) begin
          rdata_d = (opcode_q == OP_WRITE) ? wdata_q : bus.i_wbm_dat;
        end else if (expired) begin
          timeout_d = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.out_ready && burst_more) begin
          addr_d   = addr_q + 32'd1;
          remain_d = remain_q - 16'd1;
          timer_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      opcode_q   <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      remain_q   <= '0;
      timer_q    <= '0;
      rdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      opcode_q   <= opcode_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      remain_q   <= remain_d;
      timer_q    <= timer_d;
      rdata_q    <= rdata_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    bus.o_wbm_cyc   = (state_q == ST_BUS);
    bus.o_wbm_stb   = (state_q == ST_BUS);
    bus.o_wbm_we    = (state_q == ST_BUS) && (opcode_q == OP_WRITE);
    bus.o_wbm_sel   = (state_q == ST_BUS) ? 4'hF : 4'h0;
    bus.o_wbm_adr   = (state_q == ST_BUS) ? addr_q : 32'd0;
    bus.o_wbm_dat   = ((state_q == ST_BUS) && (opcode_q == OP_WRITE)) ? wdata_q : 32'd0;
    bus.out_en      = (state_q == ST_RESP);
    bus.out_status  = {remain_q, 10'd0, timeout_q, illegal_q, opcode_q};
    bus.out_address = addr_q;
    bus.out_data    = rdata_q;
    bus.o_busy      = (state_q != ST_IDLE) || (count_q != '0);
    bus.o_overflow  = overflow_q;
  end
endmodule

// File: tb/tb_uart_command_sequencer.sv
// Randomized bench: a command-level reference model predicts every bus access
// and response; a Wishbone slave and a response sink check them as they occur.
module tb_uart_command_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_command_sequencer_if bus_if ();

  uart_command_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  typedef struct {
    logic [31:0] status;
    logic [31:0] adr;
    logic [31:0] data;
  } resp_t;

  bus_t  exp_bus [$];
  resp_t exp_resp [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_00A0;
  endfunction

  // Expected behaviour of one accepted command, straight from the opcode rules.
  function automatic void model_cmd(input logic [31:0] cmd, input logic [31:0] adr,
                                    input logic [31:0] dat);
    logic [3:0] op;
    int         n;
    op = cmd[3:0];
    if (op == 4'h0) begin
      exp_resp.push_back('{32'h0, adr, 32'h0});
    end else if (op == 4'h1) begin
      exp_bus.push_back('{adr, 1'b1, dat});
      exp_resp.push_back('{32'h1, adr, dat});
    end else if (op == 4'h2) begin
      n = (dat[15:0] == 16'd0) ? 1 : int'(dat[15:0]);
      for (int i = 0; i < n; i++) begin
        logic [31:0] a;
        a = adr + 32'(i);
        exp_bus.push_back('{a, 1'b0, 32'h0});
        exp_resp.push_back('{{16'(n - 1 - i), 16'h0002}, a, rd_fn(a)});
      end
    end else begin
      exp_resp.push_back('{{27'h0, 1'b1, op}, adr, 32'h0});
    end
  endfunction

  // Wishbone slave with programmable ack delay
  int s_lo = 0, s_hi = 0, s_cnt = 0, s_delay = 0;
  bit s_active = 0;
  always @(negedge clk) begin
    if (rst) begin
      bus_if.i_wbm_ack = 1'b0;
      bus_if.i_wbm_dat = 32'h0;
      s_active = 0;
    end else if (bus_if.i_wbm_ack) begin
      bus_if.i_wbm_ack = 1'b0;
      s_active = 0;
    end else if (bus_if.o_wbm_stb) begin
      if (!s_active) begin
        s_active = 1;
        s_cnt    = 0;
        s_delay  = $urandom_range(s_lo, s_hi);
        check("bus_cyc", bus_if.o_wbm_cyc, 1);
        check("bus_sel", bus_if.o_wbm_sel, 4'hF);
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", 1, 0);
        end else begin
          bus_t b;
          b = exp_bus.pop_front();
          check("bus_adr", bus_if.o_wbm_adr, b.adr);
          check("bus_we", bus_if.o_wbm_we, b.we);
          if (b.we) check("bus_dat", bus_if.o_wbm_dat, b.dat);
        end
      end else begin
        s_cnt++;
      end
      if (s_cnt == s_delay) begin
        bus_if.i_wbm_ack = 1'b1;
        bus_if.i_wbm_dat = rd_fn(bus_if.o_wbm_adr);
      end
    end else begin
      s_active = 0;
    end
  end

  // Response sink with random or held backpressure
  bit          sink_hold = 0;
  int          ready_pct = 100;
  bit          r_seen = 0;
  logic [31:0] r_status, r_adr, r_data;
  always @(negedge clk) begin
    if (rst) begin
      bus_if.out_ready = 1'b0;
      r_seen = 0;
    end else begin
      if (bus_if.out_en) begin
        if (!r_seen) begin
          if (exp_resp.size() == 0) begin
            check("resp_unexpected", 1, 0);
          end else begin
            resp_t r;
            r = exp_resp.pop_front();
            check("resp_status", bus_if.out_status, r.status);
            check("resp_addr", bus_if.out_address, r.adr);
            check("resp_data", bus_if.out_data, r.data);
          end
          r_seen   = 1;
          r_status = bus_if.out_status;
          r_adr    = bus_if.out_address;
          r_data   = bus_if.out_data;
        end else begin
          check("hold_status", bus_if.out_status, r_status);
          check("hold_addr", bus_if.out_address, r_adr);
          check("hold_data", bus_if.out_data, r_data);
        end
      end
      bus_if.out_ready = sink_hold ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      if (bus_if.out_en && bus_if.out_ready) r_seen = 0;
    end
  end

  // Activity counters
  int cyc_count = 0, ovf_count = 0, stb_len = 0, last_stb_len = 0;
  always @(negedge clk) begin
    if (bus_if.o_wbm_cyc) cyc_count++;
    if (bus_if.o_overflow) ovf_count++;
    if (bus_if.o_wbm_stb) begin
      stb_len++;
    end else if (stb_len != 0) begin
      last_stb_len = stb_len;
      stb_len = 0;
    end
  end

  task automatic push_cmd(input logic [31:0] cmd, input logic [31:0] adr,
                          input logic [31:0] dat, input bit accepted);
    bus_if.in_command = cmd;
    bus_if.in_address = adr;
    bus_if.in_data    = dat;
    bus_if.in_ready   = 1'b1;
    if (accepted) model_cmd(cmd, adr, dat);
    @(negedge clk);
    bus_if.in_ready = 1'b0;
    $display("cmd 0x%08h adr 0x%08h dat 0x%08h accepted=%0d", cmd, adr, dat, accepted);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (t < budget && !(exp_bus.size() == 0 && exp_resp.size() == 0 && !bus_if.o_busy)) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (t >= budget), 0);
  endtask

  initial begin
    int base;
    bus_if.in_command = 32'h0;
    bus_if.in_address = 32'h0;
    bus_if.in_data    = 32'h0;
    bus_if.in_ready   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cyc_stb", {bus_if.o_wbm_cyc, bus_if.o_wbm_stb, bus_if.o_wbm_we}, 0);
    check("rst_wb_bus", {bus_if.o_wbm_sel, bus_if.o_wbm_adr, bus_if.o_wbm_dat}, 0);
    check("rst_out", {bus_if.out_status, bus_if.out_address}, 0);
    check("rst_flags", {bus_if.out_data, bus_if.out_en, bus_if.o_busy, bus_if.o_overflow}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write with a 3-cycle ack, plus push-to-strobe latency
    s_lo = 3; s_hi = 3;
    bus_if.in_command = 32'h1;
    bus_if.in_address = 32'h100;
    bus_if.in_data    = 32'hDEADBEEF;
    bus_if.in_ready   = 1'b1;
    model_cmd(32'h1, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    bus_if.in_ready = 1'b0;
    check("lat_stb_c1", bus_if.o_wbm_stb, 0);
    @(negedge clk);
    check("lat_stb_c2", bus_if.o_wbm_stb, 1);
    wait_idle(200);
    check("write_stb_len", last_stb_len, 4);

    // Burst read across the 32-bit address wrap
    s_lo = 1; s_hi = 1;
    push_cmd(32'h2, 32'hFFFF_FFFE, 32'h3, 1);
    wait_idle(300);

    // Timeout on the first word of a two-word read aborts the burst
    s_lo = 32'h0001_0000; s_hi = 32'h0001_0000;
    exp_bus.push_back('{32'h40, 1'b0, 32'h0});
    exp_resp.push_back('{32'h0001_0022, 32'h40, 32'h0});
    push_cmd(32'h2, 32'h40, 32'h2, 0);
    wait_idle(3000);
    check("timeout_stb_len", last_stb_len, 1024);

    // Backpressure and overflow: one executing, four queued, one dropped
    s_lo = 0; s_hi = 2;
    sink_hold = 1;
    base = ovf_count;
    for (int i = 0; i < 6; i++) begin
      push_cmd(32'h1, 32'h200 + 32'(i), 32'h1000 + 32'(i), (i < 5));
    end
    repeat (20) @(negedge clk);
    check("ovf_pulses", ovf_count - base, 1);
    check("busy_held", bus_if.o_busy, 1);
    sink_hold = 0;
    wait_idle(500);

    // Illegal opcode and ping never touch the bus
    base = cyc_count;
    push_cmd(32'h7, 32'h300, 32'h55, 1);
    push_cmd(32'h0, 32'h304, 32'h66, 1);
    wait_idle(200);
    check("no_cyc_ping_illegal", cyc_count - base, 0);

    // Randomized traffic with random backpressure and ack latency
    for (int it = 0; it < 40; it++) begin
      int ncmd;
      ready_pct = $urandom_range(30, 100);
      s_lo = 0;
      s_hi = $urandom_range(0, 5);
      ncmd = $urandom_range(1, 3);
      for (int k = 0; k < ncmd; k++) begin
        logic [31:0] cmd, adr, dat;
        cmd = $urandom();
        adr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom();
        dat = $urandom();
        case ($urandom_range(0, 5))
          0:       cmd[3:0] = 4'h0;
          1, 2:    cmd[3:0] = 4'h1;
          3, 4:    begin cmd[3:0] = 4'h2; dat[15:0] = 16'($urandom_range(0, 4)); end
          default: cmd[3:0] = 4'($urandom_range(3, 15));
        endcase
        push_cmd(cmd, adr, dat, 1);
      end
      wait_idle(2000);
    end
    ready_pct = 100;

    // Reset in the middle of a burst with more commands queued
    s_lo = 32'h0001_0000; s_hi = 32'h0001_0000;
    exp_bus.push_back('{32'h500, 1'b0, 32'h0});
    push_cmd(32'h2, 32'h500, 32'h4, 0);
    begin
      int t;
      t = 0;
      while (!bus_if.o_wbm_stb && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("burst_stb_seen", bus_if.o_wbm_stb, 1);
    end
    push_cmd(32'h1, 32'h600, 32'h1, 0);
    push_cmd(32'h0, 32'h604, 32'h2, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cyc_stb", {bus_if.o_wbm_cyc, bus_if.o_wbm_stb}, 0);
    check("rst_mid_out_en", bus_if.out_en, 0);
    check("rst_mid_busy", bus_if.o_busy, 0);
    exp_bus.delete();
    exp_resp.delete();
    rst = 1'b0;
    base = cyc_count;
    repeat (10) @(negedge clk);
    check("post_rst_no_cyc", cyc_count - base, 0);
    check("post_rst_busy", bus_if.o_busy, 0);
    check("post_rst_out_en", bus_if.out_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
